wide_ram_stream_reader: RTL and testbench
=========================================

// Module: wide_ram_stream_reader
// PURPOSE
//  Playback stage on the read side of the asymmetric (narrow-write / wide-read) waveform RAM.
//  On a start command it walks addrB from start_addr for length words.
//  It drives the RAM read port (enaB/addrB) and absorbs the RAM's 1-cycle registered read latency.
//  It presents the wide words as a valid/ready stream with tlast, so the downstream DAC/envelope
//  consumer can backpressure without losing words.
// PARAMETERS
//  DATAWIDTHB  512  RAM read width = stream data width
//  ADDRWIDTHB  10   RAM read address width; addresses wrap modulo 2**ADDRWIDTHB
//  FIFO_DEPTH  4    output buffer entries (fixed 4; other values unsupported)
// PORTS
//  clk         in   1             single clock (RAM port-B clock is the same clk)
//  reset       in   1             synchronous, active-high reset
//  start       in   1             1-cycle command; sampled only when busy=0 and done=0
//  start_addr  in   ADDRWIDTHB    first wide-word address
//  length      in   ADDRWIDTHB+1  number of wide words to play (0..2**(ADDRWIDTHB+1)-1)
//  busy        out  1             playback in progress
//  done        out  1             1-cycle pulse after the final beat is accepted
//  ram_ena     out  1             to RAM enaB; high only on cycles that issue a read
//  ram_addr    out  ADDRWIDTHB    to RAM addrB
//  ram_dout    in   DATAWIDTHB    from RAM doB; valid the cycle after ram_ena=1
//  m_tdata     out  DATAWIDTHB    stream data (FIFO head)
//  m_tvalid    out  1             stream valid
//  m_tready    in   1             stream ready
//  m_tlast     out  1             high with the final word of a playback
// BEHAVIOUR
//  Interface: one clock, clk; reset is synchronous and active-high.
//  Reset: busy=0, done=0, ram_ena=0, ram_addr=0, m_tvalid=0, m_tlast=0, m_tdata=0.
//   Reset clears the FIFO, the issue counter, the beat counter, and the in-flight flag.
//   Reset mid-playback abandons the playback. No done pulse follows.
//  FSM states:
//   IDLE: accepts start.
//     - length!=0 -> RUN.
//     - length==0 -> DONE (no beats, no reads).
//   RUN: issues reads.
//     - Moves to DRAIN once the last read has been issued.
//   DRAIN: waits for all issued words to be accepted downstream.
//     - On the final handshake -> DONE.
//   DONE: done=1 for exactly one cycle -> IDLE.
//  busy=1 in RUN and DRAIN, else 0. A start asserted while busy=1 or done=1 is ignored.
//  Read issue rule (registered quantities only):
//   - Condition: ram_ena=1 in a RUN cycle iff occ + inflight <= FIFO_DEPTH-2.
//     (occ = FIFO entries; inflight = read issued the previous cycle.)
//   - Each issue increments ram_addr modulo 2**ADDRWIDTHB (0x3FF -> 0x000 for the default width).
//   - The issue counter decrements on each issue.
//  Capture: on the cycle after an issue, ram_dout is written into the FIFO.
//   - No other cycle writes the FIFO.
//   - Because enaB=0 holds the RAM output, capture depends only on the inflight flag.
//  Stream: m_tvalid = (occ!=0); m_tdata = head entry.
//   - A beat is popped when m_tvalid & m_tready.
//   - A push and a pop in the same cycle are both honoured.
//   - m_tlast is a per-entry tag, set on the entry from the length-th issued read.
//   - m_tdata/m_tlast stay stable while m_tvalid=1 and m_tready=0.
//  Latency: start in cycle 0 -> ram_ena=1, ram_addr=start_addr in cycle 1 -> m_tvalid=1 in cycle 3.
//  Throughput: with m_tready held 1, one word/cycle sustained. The FIFO never overflows.
//  done timing: the final handshake is at cycle T -> done=1, busy=0 at T+1 -> new start accepted at T+2.
//  length==0: start in cycle 0 -> done=1 in cycle 1; busy, ram_ena, m_tvalid stay 0.
// TESTING
//  1. start_addr=0x010, length=4, m_tready=1.
//     -> ram_addr 0x010..0x013 in cycles 1-4; m_tvalid cycles 3-6; tlast in cycle 6; done in cycle 7.
//  2. start_addr=0x3FE, length=4.
//     -> reads 0x3FE,0x3FF,0x000,0x001; data order matches the RAM contents at those addresses.
//  3. length=16; m_tready toggled pseudo-randomly, including 10 cycles held low.
//     -> all 16 words delivered in order, with no loss or duplication.
//     -> ram_ena is never issued when occ+inflight>2; tdata held stable under stall.
//  4. length=0.
//     -> done pulse in cycle 1; no ram_ena, no m_tvalid, busy stays 0.
//  5. start re-pulsed at cycle 5 of a length=8 playback.
//     -> ignored; exactly 8 beats, one done.
//  6. reset asserted in cycle 4 of a length=8 playback.
//     -> next cycle all outputs at reset values; no done; a fresh start plays correctly.

Source files
------------

// File: rtl/wide_ram_stream_reader.sv
// Playback reader for the wide-read waveform RAM port.
// Issues sequential reads and buffers the wide words behind a valid/ready stream.
module wide_ram_stream_reader #(
   parameter int DATAWIDTHB = 512,
   parameter int ADDRWIDTHB = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDRWIDTHB-1:0] start_addr,
   input  logic [ADDRWIDTHB:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_ena,
   output logic [ADDRWIDTHB-1:0] ram_addr,
   input  logic [DATAWIDTHB-1:0] ram_dout,
   output logic [DATAWIDTHB-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                  state;
   logic [DATAWIDTHB-1:0]   mem [4];
   logic [3:0]              tag;
   logic [1:0]              wptr;
   logic [1:0]              rptr;
   logic [2:0]              occ;
   logic                    inflight;
   logic                    inflight_last;
   logic [ADDRWIDTHB:0]     issue_cnt;
   logic [3:0]              pending;
   logic                    issue;
   logic                    last_issue;
   logic                    pop;

   // Words already buffered plus the one still coming out of the RAM.
   assign pending    = {1'b0, occ} + {3'b000, inflight};
   assign issue      = (state == RUN) && (pending <= 4'(FIFO_DEPTH - 2));
   assign last_issue = issue && (issue_cnt == (ADDRWIDTHB+1)'(1));
   assign ram_ena    = issue;
   assign m_tvalid   = (occ != 3'd0);
   assign m_tdata    = mem[rptr];
   assign m_tlast    = m_tvalid & tag[rptr];
   assign pop        = m_tvalid & m_tready;
   assign busy       = (state == RUN) || (state == DRAIN);
   assign done       = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         ram_addr      <= '0;
         issue_cnt     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         wptr          <= 2'd0;
         rptr          <= 2'd0;
         occ           <= 3'd0;
         tag           <= 4'd0;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin
         inflight      <= issue;
         inflight_last <= last_issue;
         if (issue) begin
            ram_addr  <= ram_addr + 1'b1;
            issue_cnt <= issue_cnt - 1'b1;
         end
         // RAM output is held while enaB=0, so capture only follows an issue.
         if (inflight) begin
            mem[wptr] <= ram_dout;
            tag[wptr] <= inflight_last;
            wptr      <= wptr + 2'd1;
         end
         if (pop) rptr <= rptr + 2'd1;
         occ <= occ + {2'b00, inflight} - {2'b00, pop};
         unique case (state)
            IDLE: begin
               if (start) begin
                  ram_addr  <= start_addr;
                  issue_cnt <= length;
                  state     <= (length != '0) ? RUN : DONE;
               end
            end
            RUN:   if (last_issue) state <= DRAIN;
            DRAIN: if (pop && tag[rptr]) state <= DONE;
            DONE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wide_ram_stream_reader.sv
// Randomized bench for wide_ram_stream_reader against a RAM model
// and an address-sequence reference of the expected playback.
module tb_wide_ram_stream_reader;

   localparam int DW = 512;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy, done, ram_ena, m_tvalid, m_tlast;
   logic          m_tready = 1'b1;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dout = '0;
   logic [DW-1:0] m_tdata;

   logic [DW-1:0] ram [1024];

   int errors = 0;
   int checks = 0;

   // results of the most recent playback
   logic [DW-1:0] got_d [$];
   logic          got_l [$];
   int            ena_cyc [$];
   int            addr_q [$];
   logic [DW-1:0] exp_d [$];
   int            done_cyc, n_done, first_valid, last_hs;
   int            ena_viol, stall_viol, busy_seen, valid_seen;

   wide_ram_stream_reader #(.DATAWIDTHB(DW), .ADDRWIDTHB(AW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
      .length(length), .busy(busy), .done(done), .ram_ena(ram_ena),
      .ram_addr(ram_addr), .ram_dout(ram_dout), .m_tdata(m_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
   );

   always #5 clk = ~clk;

   // registered-read RAM, holds output when not enabled
   always @(posedge clk) if (ram_ena) ram_dout <= ram[ram_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic build_exp(input int sa, input int len);
      exp_d.delete();
      for (int i = 0; i < len; i++) exp_d.push_back(ram[(sa + i) % 1024]);
   endtask

   // drive a playback from cycle 0 and record what the DUT does
   task automatic play(input int sa, input int len, input int rmode,
                       input int repulse);
      int cyc, issued, popped;
      logic stalled;
      logic [DW-1:0] hd;
      logic hl;
      got_d.delete(); got_l.delete(); ena_cyc.delete(); addr_q.delete();
      done_cyc = -1; n_done = 0; first_valid = -1; last_hs = -1;
      ena_viol = 0; stall_viol = 0; busy_seen = 0; valid_seen = 0;
      issued = 0; popped = 0; stalled = 1'b0; hd = '0; hl = 1'b0;
      start_addr = AW'(sa);
      length = (AW+1)'(len);
      m_tready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (cyc < 300) begin
         if (stalled && (!m_tvalid || m_tdata !== hd || m_tlast !== hl))
            stall_viol++;
         if (rmode == 1)
            m_tready = (cyc >= 6 && cyc < 16) ? 1'b0 : 1'($urandom_range(0, 1));
         else
            m_tready = 1'b1;
         start = (cyc == repulse);
         if (cyc == repulse) start_addr = AW'(sa + 100);
         if (ram_ena) begin
            ena_cyc.push_back(cyc);
            addr_q.push_back(int'(ram_addr));
            if (issued - popped > 2) ena_viol++;
            issued++;
         end
         if (busy) busy_seen++;
         if (m_tvalid) begin
            valid_seen++;
            if (first_valid < 0) first_valid = cyc;
         end
         stalled = m_tvalid && !m_tready;
         hd = m_tdata;
         hl = m_tlast;
         if (m_tvalid && m_tready) begin
            got_d.push_back(m_tdata);
            got_l.push_back(m_tlast);
            last_hs = cyc;
            popped++;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc > done_cyc + 3) break;
         tick();
         cyc++;
      end
      start = 1'b0;
      start_addr = AW'(sa);
      m_tready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, ram_ena, m_tvalid, m_tlast} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b want=00000",
                  {busy, done, ram_ena, m_tvalid, m_tlast});
      end
      checks++;
      if (ram_addr !== '0) begin
         errors++;
         $display("FAIL reset_addr got=%0h want=0", ram_addr);
      end
      checks++;
      if (m_tdata !== '0) begin
         errors++;
         $display("FAIL reset_tdata got=%0h want=0", m_tdata);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int ea [4] = '{16, 17, 18, 19};
      int bad;
      play(16, 4, 0, -1);
      build_exp(16, 4);
      bad = 0;
      if (addr_q.size() != 4 || ena_cyc.size() != 4) bad = 1;
      else
         for (int i = 0; i < 4; i++)
            if (addr_q[i] != ea[i] || ena_cyc[i] != i + 1) bad = 1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL basic_reads got=%0d issues want=4 at cycles 1-4 addr 10..13",
                  addr_q.size());
      end
      checks++;
      if (first_valid != 3) begin
         errors++;
         $display("FAIL basic_latency got=%0d want=3", first_valid);
      end
      bad = (got_d.size() != 4) ? 1 : 0;
      if (bad == 0)
         for (int i = 0; i < 4; i++)
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 3)) bad = 1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL basic_data got=%0d beats want=4 matching RAM", got_d.size());
      end
      checks++;
      if (last_hs != 6 || done_cyc != 7 || n_done != 1) begin
         errors++;
         $display("FAIL basic_done got=hs%0d/done%0d/n%0d want=hs6/done7/n1",
                  last_hs, done_cyc, n_done);
      end
   endtask

   task automatic test_wrap();
      int ea [4] = '{1022, 1023, 0, 1};
      int bad;
      play(1022, 4, 0, -1);
      build_exp(1022, 4);
      bad = (addr_q.size() != 4) ? 1 : 0;
      if (bad == 0)
         for (int i = 0; i < 4; i++) if (addr_q[i] != ea[i]) bad = 1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap_addr got=%0d issues want=3fe,3ff,0,1", addr_q.size());
      end
      bad = (got_d.size() != 4) ? 1 : 0;
      if (bad == 0)
         for (int i = 0; i < 4; i++) if (got_d[i] !== exp_d[i]) bad = 1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap_data got=%0d beats want=4 matching RAM", got_d.size());
      end
   endtask

   task automatic test_backpressure();
      int sa, bad;
      sa = $urandom_range(0, 1023);
      play(sa, 16, 1, -1);
      build_exp(sa, 16);
      bad = (got_d.size() != 16) ? 1 : 0;
      if (bad == 0)
         for (int i = 0; i < 16; i++)
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 15)) bad = 1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_data got=%0d beats want=16 in order", got_d.size());
      end
      checks++;
      if (ena_viol != 0) begin
         errors++;
         $display("FAIL bp_issue_rule got=%0d violations want=0", ena_viol);
      end
      checks++;
      if (stall_viol != 0) begin
         errors++;
         $display("FAIL bp_stable got=%0d violations want=0", stall_viol);
      end
      checks++;
      if (n_done != 1 || done_cyc != last_hs + 1) begin
         errors++;
         $display("FAIL bp_done got=n%0d/done%0d want=n1/done%0d",
                  n_done, done_cyc, last_hs + 1);
      end
   endtask

   task automatic test_zero();
      play($urandom_range(0, 1023), 0, 0, -1);
      checks++;
      if (done_cyc != 1 || n_done != 1) begin
         errors++;
         $display("FAIL zero_done got=done%0d/n%0d want=done1/n1", done_cyc, n_done);
      end
      checks++;
      if (ena_cyc.size() != 0 || valid_seen != 0 || busy_seen != 0) begin
         errors++;
         $display("FAIL zero_quiet got=ena%0d/valid%0d/busy%0d want=0/0/0",
                  ena_cyc.size(), valid_seen, busy_seen);
      end
   endtask

   task automatic test_repulse();
      int sa, bad;
      sa = $urandom_range(0, 1023);
      play(sa, 8, 0, 5);
      build_exp(sa, 8);
      bad = (got_d.size() != 8) ? 1 : 0;
      if (bad == 0)
         for (int i = 0; i < 8; i++) if (got_d[i] !== exp_d[i]) bad = 1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL repulse_data got=%0d beats want=8 from original addr",
                  got_d.size());
      end
      checks++;
      if (n_done != 1) begin
         errors++;
         $display("FAIL repulse_done got=%0d want=1", n_done);
      end
   endtask

   task automatic test_reset_mid();
      int sa, nd, bad;
      sa = $urandom_range(0, 1023);
      start_addr = AW'(sa);
      length = 11'd8;
      m_tready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({busy, done, ram_ena, m_tvalid, m_tlast} !== 5'b0 || ram_addr !== '0
          || m_tdata !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got=%b/%0h want=00000/0",
                  {busy, done, ram_ena, m_tvalid, m_tlast}, ram_addr);
      end
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy || m_tvalid) nd++;
         tick();
      end
      checks++;
      if (nd != 0) begin
         errors++;
         $display("FAIL midreset_quiet got=%0d active cycles want=0", nd);
      end
      sa = $urandom_range(0, 1023);
      play(sa, 5, 0, -1);
      build_exp(sa, 5);
      bad = (got_d.size() != 5 || n_done != 1) ? 1 : 0;
      if (bad == 0)
         for (int i = 0; i < 5; i++)
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 4)) bad = 1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midreset_replay got=%0d beats/%0d done want=5/1",
                  got_d.size(), n_done);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++)
         for (int j = 0; j < DW / 32; j++) ram[i][j*32 +: 32] = $urandom;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero();
      test_repulse();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
